// File: rtl/lift_scan_controller.sv
// SCAN-policy lift controller with a latched per-floor request bitmap.
// Define LIFT_PARK_EN to return an idle car to floor 0 after PARK_CYCLES idle cycles.
module lift_scan_controller #(
   parameter int NUM_FLOORS    = 4,
   parameter int FLOOR_W       = 2,
   parameter int TRAVEL_CYCLES = 2,
   parameter int DOOR_CYCLES   = 4,
   parameter int PARK_CYCLES   = 8
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic [NUM_FLOORS-1:0] Request,
   output logic [1:0]            Action,
   output logic [FLOOR_W-1:0]    Floor,
   output logic [NUM_FLOORS-1:0] Pending,
   output logic                  Busy
);

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      MOVE_UP   = 2'b01,
      MOVE_DOWN = 2'b10,
      DOOR      = 2'b11
   } state_t;

   localparam int TRAVEL_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
   localparam int DOOR_W   = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [TRAVEL_W-1:0]   TRAVEL_LAST = TRAVEL_W'(TRAVEL_CYCLES - 1);
   localparam logic [DOOR_W-1:0]     DOOR_LAST   = DOOR_W'(DOOR_CYCLES - 1);
   localparam logic [FLOOR_W-1:0]    TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
   localparam logic [NUM_FLOORS-1:0] ONE_HOT0    = NUM_FLOORS'(1);

   state_t                  state_q;
   logic [FLOOR_W-1:0]      floor_q;
   logic [NUM_FLOORS-1:0]   pending_q;
   logic                    dir_up_q;
   logic [TRAVEL_W-1:0]     travel_cnt_q;
   logic [DOOR_W-1:0]       door_cnt_q;

   logic                    above;
   logic                    below;
   logic                    here;
   logic                    step;
   logic                    absorb;
   logic                    arrive_hit;
   logic                    enter_door;
   logic [FLOOR_W-1:0]      arrive_floor;
   logic [FLOOR_W-1:0]      enter_floor;
   logic [NUM_FLOORS-1:0]   set_mask;
   logic [NUM_FLOORS-1:0]   clr_mask;
   logic [NUM_FLOORS-1:0]   pending_next;

`ifdef LIFT_PARK_EN
   localparam int PARK_W = (PARK_CYCLES > 1) ? $clog2(PARK_CYCLES) : 1;
   localparam logic [PARK_W-1:0] PARK_LAST = PARK_W'(PARK_CYCLES - 1);
   logic [PARK_W-1:0]       idle_cnt_q;
`endif

   // A same-floor call during DOOR is absorbed (restarts the door) instead of
   // latching; a door entry clears its floor's bit and beats a simultaneous set.
   always_comb begin
      above = 1'b0;
      below = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending_q[i] && (FLOOR_W'(i) > floor_q)) above = 1'b1;
         if (pending_q[i] && (FLOOR_W'(i) < floor_q)) below = 1'b1;
      end
      here         = pending_q[floor_q];
      arrive_floor = (state_q == MOVE_DOWN) ? floor_q - FLOOR_W'(1) : floor_q + FLOOR_W'(1);
      step         = ((state_q == MOVE_UP) || (state_q == MOVE_DOWN)) && (travel_cnt_q == TRAVEL_LAST);
      arrive_hit   = step && pending_q[arrive_floor];
      absorb       = (state_q == DOOR) && Request[floor_q];
      enter_door   = ((state_q == IDLE) && here) || arrive_hit;
      enter_floor  = (state_q == IDLE) ? floor_q : arrive_floor;
      set_mask     = Request & ~(absorb ? (ONE_HOT0 << floor_q) : '0);
      clr_mask     = enter_door ? (ONE_HOT0 << enter_floor) : '0;
      pending_next = (pending_q | set_mask) & ~clr_mask;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q      <= IDLE;
         floor_q      <= '0;
         pending_q    <= '0;
         dir_up_q     <= 1'b1;
         travel_cnt_q <= '0;
         door_cnt_q   <= '0;
`ifdef LIFT_PARK_EN
         idle_cnt_q   <= '0;
`endif
      end else begin
         pending_q <= pending_next;
`ifdef LIFT_PARK_EN
         idle_cnt_q <= '0;
`endif
         case (state_q)
            // Dir only changes here, so a car leaving DOOR resumes its sweep.
            IDLE: begin
               travel_cnt_q <= '0;
               if (here) begin
                  state_q    <= DOOR;
                  door_cnt_q <= DOOR_LAST;
               end else if (above && (dir_up_q || !below)) begin
                  state_q  <= MOVE_UP;
                  dir_up_q <= 1'b1;
               end else if (below) begin
                  state_q  <= MOVE_DOWN;
                  dir_up_q <= 1'b0;
               end
`ifdef LIFT_PARK_EN
               else if ((floor_q != '0) && (Request == '0)) begin
                  if (idle_cnt_q == PARK_LAST) begin
                     state_q  <= MOVE_DOWN;
                     dir_up_q <= 1'b0;
                  end else begin
                     idle_cnt_q <= idle_cnt_q + 1'b1;
                  end
               end
`endif
            end
            MOVE_UP, MOVE_DOWN: begin
               if (step) begin
                  floor_q      <= arrive_floor;
                  travel_cnt_q <= '0;
                  if (arrive_hit) begin
                     state_q    <= DOOR;
                     door_cnt_q <= DOOR_LAST;
                  end else if ((arrive_floor == '0) || (arrive_floor == TOP_FLOOR)) begin
                     state_q <= IDLE;
                  end
               end else begin
                  travel_cnt_q <= travel_cnt_q + 1'b1;
               end
            end
            DOOR: begin
               if (absorb) begin
                  door_cnt_q <= DOOR_LAST;
               end else if (door_cnt_q == '0) begin
                  state_q <= IDLE;
               end else begin
                  door_cnt_q <= door_cnt_q - 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign Action  = state_q;
   assign Floor   = floor_q;
   assign Pending = pending_q;
   assign Busy    = (state_q != IDLE) || (pending_q != '0);

endmodule

// File: tb/tb_lift_scan_controller.sv
// Self-checking bench for lift_scan_controller: directed scenarios plus random calls
// against a floor/timer reference model. Define LIFT_PARK_EN to also cover parking.
module tb_lift_scan_controller;

   localparam int NF     = 4;
   localparam int FW     = 2;
   localparam int TRAVEL = 2;
   localparam int DOOR   = 4;
   localparam int PARK   = 8;

   logic          Clock   = 1'b0;
   logic          Reset   = 1'b0;
   logic [NF-1:0] Request = '0;
   logic [1:0]    Action;
   logic [FW-1:0] Floor;
   logic [NF-1:0] Pending;
   logic          Busy;

   int checks = 0;
   int errors = 0;

   // Reference model: mode 0 idle, 1 up, 2 down, 3 door; timers count remaining cycles.
   int            m_mode;
   int            m_floor;
   int            m_dir;
   int            m_seg;
   int            m_door;
   int            m_idle;
   logic [NF-1:0] m_pend;

   lift_scan_controller #(
      .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(TRAVEL),
      .DOOR_CYCLES(DOOR), .PARK_CYCLES(PARK)
   ) dut (
      .Clock(Clock), .Reset(Reset), .Request(Request),
      .Action(Action), .Floor(Floor), .Pending(Pending), .Busy(Busy)
   );

   always #5 Clock = ~Clock;

   function automatic void model_reset();
      m_mode = 0; m_floor = 0; m_dir = 1; m_seg = 0; m_door = 0; m_idle = 0; m_pend = '0;
   endfunction

   function automatic void model_edge(input logic [NF-1:0] r);
      logic [NF-1:0] set_bits;
      logic [NF-1:0] clr;
      bit above, below, absorbed;
      set_bits = r; clr = '0; above = 0; below = 0; absorbed = 0;
      for (int j = 0; j < NF; j++) begin
         if (m_pend[j] && j > m_floor) above = 1;
         if (m_pend[j] && j < m_floor) below = 1;
      end
      if (m_mode == 3 && r[m_floor]) begin
         set_bits[m_floor] = 1'b0;
         absorbed = 1;
      end
      if (m_mode != 0) m_idle = 0;
      case (m_mode)
         0: begin
            if (m_pend[m_floor]) begin
               m_mode = 3; m_door = DOOR; clr[m_floor] = 1'b1; m_idle = 0;
            end else if (above && (m_dir > 0 || !below)) begin
               m_mode = 1; m_dir = 1; m_seg = TRAVEL; m_idle = 0;
            end else if (below) begin
               m_mode = 2; m_dir = -1; m_seg = TRAVEL; m_idle = 0;
            end else begin
`ifdef LIFT_PARK_EN
               if (m_floor != 0 && r == '0) m_idle++;
               else m_idle = 0;
               if (m_idle == PARK) begin
                  m_mode = 2; m_dir = -1; m_seg = TRAVEL; m_idle = 0;
               end
`endif
            end
         end
         1, 2: begin
            m_seg--;
            if (m_seg == 0) begin
               m_floor += m_dir;
               if (m_pend[m_floor]) begin
                  m_mode = 3; m_door = DOOR; clr[m_floor] = 1'b1;
               end else if (m_floor == 0 || m_floor == NF - 1) begin
                  m_mode = 0;
               end else begin
                  m_seg = TRAVEL;
               end
            end
         end
         default: begin
            if (absorbed) m_door = DOOR;
            else m_door--;
            if (m_door == 0) m_mode = 0;
         end
      endcase
      m_pend = (m_pend | set_bits) & ~clr;
   endfunction

   // Drive one cycle of Request, advance the model on the edge, sample 1 time unit later.
   task automatic applyStimulus(input logic [NF-1:0] r);
      Request = r;
      @(posedge Clock);
      model_edge(r);
      #1;
   endtask

   task automatic do_reset();
      Request = '0;
      #2 Reset = 1'b0;
      @(posedge Clock);
      #1;
      model_reset();
      Reset = 1'b1;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (Action !== 2'b00) begin errors++; $display("[TB] FAIL reset_action got %b expected 00", Action); end
      checks++; if (Floor !== 2'd0) begin errors++; $display("[TB] FAIL reset_floor got %0d expected 0", Floor); end
      checks++; if (Pending !== 4'b0000) begin errors++; $display("[TB] FAIL reset_pending got %b expected 0000", Pending); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", Busy); end
   endtask

   task automatic test_single_request();
      logic [1:0]    ea [10] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
      logic [FW-1:0] ef [10] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
      logic [NF-1:0] ep [10] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                                 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      logic          eb [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(i == 0 ? 4'b0100 : 4'b0000);
         checks++; if (Action !== ea[i]) begin errors++; $display("[TB] FAIL single_action[%0d] got %b expected %b", i, Action, ea[i]); end
         checks++; if (Floor !== ef[i]) begin errors++; $display("[TB] FAIL single_floor[%0d] got %0d expected %0d", i, Floor, ef[i]); end
         checks++; if (Pending !== ep[i]) begin errors++; $display("[TB] FAIL single_pending[%0d] got %b expected %b", i, Pending, ep[i]); end
         checks++; if (Busy !== eb[i]) begin errors++; $display("[TB] FAIL single_busy[%0d] got %b expected %b", i, Busy, eb[i]); end
      end
   endtask

   task automatic test_same_floor();
      logic [1:0]    ea [6] = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
      logic [NF-1:0] ep [6] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(i == 0 ? 4'b0001 : 4'b0000);
         checks++; if (Action !== ea[i]) begin errors++; $display("[TB] FAIL same_action[%0d] got %b expected %b", i, Action, ea[i]); end
         checks++; if (Floor !== 2'd0) begin errors++; $display("[TB] FAIL same_floor[%0d] got %0d expected 0", i, Floor); end
         checks++; if (Pending !== ep[i]) begin errors++; $display("[TB] FAIL same_pending[%0d] got %b expected %b", i, Pending, ep[i]); end
      end
   endtask

   task automatic test_scan_order();
      int            door_floor [$];
      logic [1:0]    door_from  [$];
      logic [NF-1:0] pend_seq   [$];
      logic [1:0]    prev_act;
      logic [NF-1:0] prev_pend;
      bit            done = 0;
      do_reset();
      applyStimulus(4'b1000);
      for (int i = 0; i < 3; i++) applyStimulus(4'b0000);
      checks++; if (Floor !== 2'd1 || Action !== 2'b01) begin errors++; $display("[TB] FAIL scan_setup got floor %0d action %b expected 1 01", Floor, Action); end
      applyStimulus(4'b0101);
      checks++; if (Pending !== 4'b1101) begin errors++; $display("[TB] FAIL scan_latch got %b expected 1101", Pending); end
      prev_act = Action; prev_pend = Pending;
      for (int i = 0; i < 40 && !done; i++) begin
         applyStimulus(4'b0000);
         checks++; if (Action !== 2'(m_mode) || Pending !== m_pend) begin errors++; $display("[TB] FAIL scan_model[%0d] got %b/%b expected %b/%b", i, Action, Pending, 2'(m_mode), m_pend); end
         if (Action == 2'b11 && prev_act != 2'b11) begin door_floor.push_back(int'(Floor)); door_from.push_back(prev_act); end
         if (Pending != prev_pend) pend_seq.push_back(Pending);
         prev_act = Action; prev_pend = Pending;
         if (!Busy) done = 1;
      end
      checks++; if (!done) begin errors++; $display("[TB] FAIL scan_timeout got busy expected idle within 40 cycles"); end
      checks++;
      if (door_floor.size() != 3 || pend_seq.size() != 3) begin
         errors++; $display("[TB] FAIL scan_counts got %0d doors %0d pending steps expected 3 3", door_floor.size(), pend_seq.size());
      end else begin
         if (door_floor[0] != 2 || door_floor[1] != 3 || door_floor[2] != 0) begin errors++; $display("[TB] FAIL scan_doors got %0d,%0d,%0d expected 2,3,0", door_floor[0], door_floor[1], door_floor[2]); end
         checks++; if (door_from[0] !== 2'b01 || door_from[1] !== 2'b01 || door_from[2] !== 2'b10) begin errors++; $display("[TB] FAIL scan_dirs got %b,%b,%b expected 01,01,10", door_from[0], door_from[1], door_from[2]); end
         checks++; if (pend_seq[0] !== 4'b1001 || pend_seq[1] !== 4'b0001 || pend_seq[2] !== 4'b0000) begin errors++; $display("[TB] FAIL scan_pending got %b,%b,%b expected 1001,0001,0000", pend_seq[0], pend_seq[1], pend_seq[2]); end
      end
   endtask

   task automatic test_door_extension();
      int door_len = 3;
      bit pend1_seen = 0;
      bit closed = 0;
      do_reset();
      applyStimulus(4'b0010);
      for (int i = 0; i < 3; i++) applyStimulus(4'b0000);
      checks++; if (Action !== 2'b11 || Floor !== 2'd1) begin errors++; $display("[TB] FAIL ext_open got %b floor %0d expected 11 floor 1", Action, Floor); end
      applyStimulus(4'b0000);
      applyStimulus(4'b0010);
      checks++; if (Action !== 2'b11 || Pending !== 4'b0000) begin errors++; $display("[TB] FAIL ext_absorb got %b/%b expected 11/0000", Action, Pending); end
      for (int i = 0; i < 20 && !closed; i++) begin
         applyStimulus(4'b0000);
         if (Pending[1]) pend1_seen = 1;
         if (Action == 2'b11) door_len++;
         else closed = 1;
      end
      checks++; if (door_len != 6 || !closed) begin errors++; $display("[TB] FAIL ext_length got %0d cycles expected 6", door_len); end
      checks++; if (pend1_seen) begin errors++; $display("[TB] FAIL ext_pending got Pending[1]=1 expected 0"); end
   endtask

   task automatic test_async_reset();
      bit found = 0;
      do_reset();
      applyStimulus(4'b1000);
      for (int i = 0; i < 10 && !found; i++) begin
         applyStimulus(4'b0000);
         if (Floor == 2'd2 && Action == 2'b01) found = 1;
      end
      checks++; if (!found || Pending !== 4'b1000) begin errors++; $display("[TB] FAIL arst_setup got floor %0d pending %b expected 2 1000", Floor, Pending); end
      #2 Reset = 1'b0;
      #1;
      checks++; if (Action !== 2'b00) begin errors++; $display("[TB] FAIL arst_action got %b expected 00", Action); end
      checks++; if (Floor !== 2'd0) begin errors++; $display("[TB] FAIL arst_floor got %0d expected 0", Floor); end
      checks++; if (Pending !== 4'b0000 || Busy !== 1'b0) begin errors++; $display("[TB] FAIL arst_pending got %b busy %b expected 0000 0", Pending, Busy); end
      @(posedge Clock);
      #1;
      model_reset();
      Reset = 1'b1;
   endtask

   task automatic test_random();
      logic [NF-1:0] r;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         r = '0;
         for (int b = 0; b < NF; b++) if ($urandom_range(0, 11) == 0) r[b] = 1'b1;
         applyStimulus(r);
         checks++; if (Action !== 2'(m_mode)) begin errors++; $display("[TB] FAIL rand_action[%0d] got %b expected %b", i, Action, 2'(m_mode)); end
         checks++; if (Floor !== FW'(m_floor)) begin errors++; $display("[TB] FAIL rand_floor[%0d] got %0d expected %0d", i, Floor, m_floor); end
         checks++; if (Pending !== m_pend) begin errors++; $display("[TB] FAIL rand_pending[%0d] got %b expected %b", i, Pending, m_pend); end
         checks++; if (Busy !== (m_mode != 0 || m_pend != '0)) begin errors++; $display("[TB] FAIL rand_busy[%0d] got %b expected %b", i, Busy, (m_mode != 0 || m_pend != '0)); end
      end
   endtask

`ifdef LIFT_PARK_EN
   task automatic test_park();
      bit settled = 0;
      int idle_n = 1;
      int down_n = 1;
      do_reset();
      applyStimulus(4'b1000);
      for (int i = 0; i < 30 && !settled; i++) begin
         applyStimulus(4'b0000);
         if (Action == 2'b00 && !Busy) settled = 1;
      end
      checks++; if (!settled || Floor !== 2'd3) begin errors++; $display("[TB] FAIL park_setup got floor %0d expected idle at 3", Floor); end
      for (int i = 0; i < 20 && Action == 2'b00; i++) begin
         applyStimulus(4'b0000);
         if (Action == 2'b00) idle_n++;
      end
      checks++; if (idle_n != PARK || Action !== 2'b10) begin errors++; $display("[TB] FAIL park_idle got %0d idle then %b expected %0d then 10", idle_n, Action, PARK); end
      for (int i = 0; i < 20 && Action == 2'b10; i++) begin
         applyStimulus(4'b0000);
         if (Action == 2'b10) down_n++;
      end
      checks++; if (down_n != 3 * TRAVEL) begin errors++; $display("[TB] FAIL park_travel got %0d expected %0d", down_n, 3 * TRAVEL); end
      checks++; if (Action !== 2'b00 || Floor !== 2'd0) begin errors++; $display("[TB] FAIL park_end got %b floor %0d expected 00 floor 0", Action, Floor); end
   endtask
`endif

   initial begin
      model_reset();
      test_reset();
      test_single_request();
      test_same_floor();
      test_scan_order();
      test_door_extension();
      test_async_reset();
`ifdef LIFT_PARK_EN
      test_park();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got no finish expected completion before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
